// File: rtl/alu_ctrl_pipe_if.sv
// alu_ctrl_pipe_if: instruction-in / decoded-ALU-control-out handshake bundle.
interface alu_ctrl_pipe_if #(parameter int XLEN = 64);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic            out_valid;
  logic            out_ready;
  logic [5:0]      out_op;
  logic            out_is_add;
  logic            out_type_i;
  logic            out_signed;
  logic            out_word;
  logic            out_muldiv;
  logic            out_illegal;
  logic [XLEN-1:0] out_imm;
  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_op, out_is_add, out_type_i, out_signed,
           out_word, out_muldiv, out_illegal, out_imm
  );
  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_op, out_is_add, out_type_i, out_signed,
           out_word, out_muldiv, out_illegal, out_imm
  );
endinterface

// File: rtl/alu_ctrl_pipe.sv
// alu_ctrl_pipe: RV32/RV64 ALU-control decoder behind a 2-entry skid buffer,
// with a saturating count of accepted illegal encodings.
module alu_ctrl_pipe #(
  parameter int XLEN  = 64,
  parameter int EN_M  = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] illegal_cnt,
  alu_ctrl_pipe_if.slave   bus
);
  localparam logic [7:0][5:0] R0 = {6'd14, 6'd13, 6'd9, 6'd8, 6'd7, 6'd6, 6'd4, 6'd0};
  localparam logic [7:0][5:0] I0 = {6'd21, 6'd20, 6'd63, 6'd19, 6'd18, 6'd17, 6'd63, 6'd15};
  logic [6:0]      opc, f7;
  logic [2:0]      f3;
  logic            sh_ok;
  logic [5:0]      dop, e0_op, e1_op;
  logic [XLEN-1:0] dimm, e0_imm, e1_imm;
  logic            e0_v, e1_v, acc, drain, to_e1;
  assign opc   = bus.in_instr[6:0];
  assign f3    = bus.in_instr[14:12];
  assign f7    = bus.in_instr[31:25];
  assign sh_ok = (XLEN == 64) || !bus.in_instr[25];
  always_comb begin
    dop = 6'd63;
    case (opc)
      7'b0110011: dop = f7 == 7'h00 ? R0[f3] :
                        f7 == 7'h20 && f3 == 3'd0 ? 6'd2 :
                        f7 == 7'h20 && f3 == 3'd5 ? 6'd11 :
                        f7 == 7'h01 && EN_M != 0 ? 6'd30 + 6'(f3) : 6'd63;
      7'b0111011: if (XLEN == 64)
        dop = f7 == 7'h00 ? (f3 == 3'd0 ? 6'd1 : f3 == 3'd1 ? 6'd5 : f3 == 3'd5 ? 6'd10 : 6'd63) :
              f7 == 7'h20 ? (f3 == 3'd0 ? 6'd3 : f3 == 3'd5 ? 6'd12 : 6'd63) :
              f7 == 7'h01 && EN_M != 0 ? (f3 == 3'd0 ? 6'd38 : f3 >= 3'd4 ? 6'd35 + 6'(f3) : 6'd63) : 6'd63;
      7'b0010011: dop = f3 == 3'd1 ? (sh_ok && bus.in_instr[31:26] == 6'b000000 ? 6'd22 : 6'd63) :
                        f3 == 3'd5 ? (!sh_ok ? 6'd63 :
                                      bus.in_instr[31:26] == 6'b000000 ? 6'd24 :
                                      bus.in_instr[31:26] == 6'b010000 ? 6'd26 : 6'd63) : I0[f3];
      7'b0011011: if (XLEN == 64)
        dop = f3 == 3'd0 ? 6'd16 :
              f3 == 3'd1 ? (f7 == 7'h00 ? 6'd23 : 6'd63) :
              f3 == 3'd5 ? (f7 == 7'h00 ? 6'd25 : f7 == 7'h20 ? 6'd27 : 6'd63) : 6'd63;
      7'b0110111: dop = 6'd28;
      7'b0010111: dop = 6'd29;
      default:    dop = 6'd63;
    endcase
  end
  always_comb begin
    dimm = (dop >= 6'd15 && dop <= 6'd21) ? XLEN'($signed(bus.in_instr[31:20])) :
           (dop == 6'd22 || dop == 6'd24 || dop == 6'd26) ? XLEN'(bus.in_instr[25:20]) :
           (dop == 6'd23 || dop == 6'd25 || dop == 6'd27) ? XLEN'(bus.in_instr[24:20]) :
           (dop == 6'd28 || dop == 6'd29) ? XLEN'($signed({bus.in_instr[31:12], 12'h000})) : '0;
  end
  assign acc   = bus.in_valid && !e1_v && !flush;
  assign drain = e0_v && bus.out_ready;
  assign to_e1 = acc && e0_v && !drain;
  // E1 only ever fills while E0 is held, so E0 refills from E1 first when draining
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_v   <= 1'b0;
      e1_v   <= 1'b0;
      e0_op  <= 6'd63;
      e1_op  <= 6'd63;
      e0_imm <= '0;
      e1_imm <= '0;
    end else if (flush) begin
      e0_v <= 1'b0;
      e1_v <= 1'b0;
    end else begin
      if (drain || !e0_v) begin
        e0_v   <= e1_v || acc;
        e0_op  <= e1_v ? e1_op : acc ? dop : e0_op;
        e0_imm <= e1_v ? e1_imm : acc ? dimm : e0_imm;
      end
      e1_v <= e1_v ? !drain : to_e1;
      if (to_e1) begin
        e1_op  <= dop;
        e1_imm <= dimm;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_cnt <= '0;
    else if (cnt_clr) illegal_cnt <= '0;
    else if (acc && dop == 6'd63 && illegal_cnt != '1) illegal_cnt <= illegal_cnt + 1'b1;
  end
  assign bus.in_ready    = !e1_v;
  assign bus.out_valid   = e0_v;
  assign bus.out_op      = e0_op;
  assign bus.out_imm     = e0_imm;
  assign bus.out_is_add  = e0_op == 6'd0 || e0_op == 6'd1 || e0_op == 6'd15 || e0_op == 6'd16;
  assign bus.out_type_i  = e0_op >= 6'd15 && e0_op <= 6'd29;
  assign bus.out_signed  = !(e0_op == 6'd7 || e0_op == 6'd18 || e0_op == 6'd33 || e0_op == 6'd35 ||
                             e0_op == 6'd37 || e0_op == 6'd40 || e0_op == 6'd42);
  assign bus.out_word    = e0_op == 6'd1 || e0_op == 6'd3 || e0_op == 6'd5 || e0_op == 6'd10 ||
                           e0_op == 6'd12 || e0_op == 6'd16 || e0_op == 6'd23 || e0_op == 6'd25 ||
                           e0_op == 6'd27 || (e0_op >= 6'd38 && e0_op <= 6'd42);
  assign bus.out_muldiv  = e0_op >= 6'd30 && e0_op <= 6'd42;
  assign bus.out_illegal = e0_op == 6'd63;
endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// tb_alu_ctrl_pipe: directed checks of an RV64+M decoder and an RV32/no-M decoder fed the same instructions.
module tb_alu_ctrl_pipe;
  logic       clk = 1'b0;
  logic       rst_n, flush, cnt_clr;
  logic [7:0] cnt_a, cnt_b;
  int         passed = 0, total = 0;
  localparam logic [31:0] ADD = 32'h003100B3, ADDI = 32'hFFF00093, ADDIW = 32'hFFF0009B;
  localparam logic [31:0] DIVU = 32'h0220D0B3, SUB = 32'h403100B3, XOR = 32'h003140B3;
  localparam logic [31:0] SLTU = 32'h003130B3, OR = 32'h003160B3, ILL = 32'hFFFFFFFF;
  localparam logic [31:0] SRAI = 32'h43F15093, LUI = 32'h800000B7, SRAIW = 32'h41F1509B;
  localparam logic [31:0] SLLBAD = 32'h403110B3;
  alu_ctrl_pipe_if #(.XLEN(64)) ia ();
  alu_ctrl_pipe_if #(.XLEN(32)) ib ();
  alu_ctrl_pipe #(.XLEN(64), .EN_M(1), .CNT_W(8)) ua (
    .clk(clk), .rst_n(rst_n), .flush(flush), .cnt_clr(cnt_clr), .illegal_cnt(cnt_a), .bus(ia.slave));
  alu_ctrl_pipe #(.XLEN(32), .EN_M(0), .CNT_W(8)) ub (
    .clk(clk), .rst_n(rst_n), .flush(flush), .cnt_clr(cnt_clr), .illegal_cnt(cnt_b), .bus(ib.slave));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drv(input logic v, input logic [31:0] i);
    ia.in_valid = v;
    ia.in_instr = i;
    ib.in_valid = v;
    ib.in_instr = i;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    cnt_clr = 1'b0;
    ia.out_ready = 1'b1;
    ib.out_ready = 1'b1;
    drv(1'b0, 32'h0);
    step();
    step();
    chk("rst_out_valid", ia.out_valid, 0);
    chk("rst_in_ready", ia.in_ready, 1);
    chk("rst_op", ia.out_op, 63);
    chk("rst_illegal", ia.out_illegal, 1);
    chk("rst_signed", ia.out_signed, 1);
    chk("rst_is_add", ia.out_is_add, 0);
    chk("rst_imm", ia.out_imm, 0);
    chk("rst_cnt", cnt_a, 0);
    rst_n = 1'b1;
    drv(1'b1, ADD);
    step();
    chk("add_valid", ia.out_valid, 1);
    chk("add_op", ia.out_op, 0);
    chk("add_is_add", ia.out_is_add, 1);
    chk("add_type_i", ia.out_type_i, 0);
    chk("add_signed", ia.out_signed, 1);
    chk("add_imm", ia.out_imm, 0);
    chk("add_op_b", ib.out_op, 0);
    drv(1'b1, ADDI);
    step();
    chk("addi_op", ia.out_op, 15);
    chk("addi_type_i", ia.out_type_i, 1);
    chk("addi_imm", ia.out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addi_imm_b", ib.out_imm, 64'hFFFF_FFFF);
    drv(1'b1, ADDIW);
    step();
    chk("addiw_op", ia.out_op, 16);
    chk("addiw_word", ia.out_word, 1);
    chk("addiw_op_b", ib.out_op, 63);
    chk("addiw_illegal_b", ib.out_illegal, 1);
    chk("addiw_cnt_b", cnt_b, 1);
    chk("addiw_cnt_a", cnt_a, 0);
    drv(1'b1, DIVU);
    step();
    chk("divu_op", ia.out_op, 35);
    chk("divu_muldiv", ia.out_muldiv, 1);
    chk("divu_signed", ia.out_signed, 0);
    chk("divu_op_b", ib.out_op, 63);
    chk("divu_cnt_b", cnt_b, 2);
    drv(1'b0, 32'h0);
    step();
    chk("drain_valid", ia.out_valid, 0);
    ia.out_ready = 1'b0;
    drv(1'b1, SUB);
    step();
    chk("bp1_op", ia.out_op, 2);
    chk("bp1_in_ready", ia.in_ready, 1);
    drv(1'b1, XOR);
    step();
    chk("bp2_in_ready", ia.in_ready, 0);
    chk("bp2_op", ia.out_op, 2);
    drv(1'b1, SLTU);
    step();
    chk("bp3_in_ready", ia.in_ready, 0);
    chk("bp3_op", ia.out_op, 2);
    chk("bp3_valid", ia.out_valid, 1);
    ia.out_ready = 1'b1;
    step();
    chk("rel1_op", ia.out_op, 8);
    chk("rel1_in_ready", ia.in_ready, 1);
    step();
    chk("rel2_op", ia.out_op, 7);
    chk("rel2_signed", ia.out_signed, 0);
    drv(1'b0, 32'h0);
    step();
    chk("rel3_valid", ia.out_valid, 0);
    ia.out_ready = 1'b0;
    drv(1'b1, ADD);
    step();
    drv(1'b1, OR);
    step();
    chk("fl_full", ia.in_ready, 0);
    drv(1'b1, ILL);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drv(1'b0, 32'h0);
    chk("fl_valid", ia.out_valid, 0);
    chk("fl_in_ready", ia.in_ready, 1);
    chk("fl_valid_b", ib.out_valid, 0);
    chk("fl_cnt_b", cnt_b, 2);
    ia.out_ready = 1'b1;
    drv(1'b1, ILL);
    step();
    chk("ill_cnt1", cnt_a, 1);
    repeat (299) step();
    chk("sat_a", cnt_a, 255);
    chk("sat_b", cnt_b, 255);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("clr_a", cnt_a, 0);
    chk("clr_b", cnt_b, 0);
    step();
    chk("after_clr", cnt_a, 1);
    drv(1'b1, SRAI);
    step();
    chk("srai_op", ia.out_op, 26);
    chk("srai_imm", ia.out_imm, 63);
    chk("srai_op_b", ib.out_op, 63);
    drv(1'b1, LUI);
    step();
    chk("lui_op", ia.out_op, 28);
    chk("lui_imm", ia.out_imm, 64'hFFFF_FFFF_8000_0000);
    chk("lui_imm_b", ib.out_imm, 64'h8000_0000);
    drv(1'b1, SRAIW);
    step();
    chk("sraiw_op", ia.out_op, 27);
    chk("sraiw_word", ia.out_word, 1);
    chk("sraiw_imm", ia.out_imm, 31);
    drv(1'b1, SLLBAD);
    step();
    chk("sllbad_op", ia.out_op, 63);
    chk("sllbad_illegal", ia.out_illegal, 1);
    ia.out_ready = 1'b0;
    drv(1'b1, ADD);
    step();
    step();
    chk("mid_full", ia.in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", ia.out_valid, 0);
    chk("mid_rst_in_ready", ia.in_ready, 1);
    chk("mid_rst_op", ia.out_op, 63);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
